fade_cycle_sequencer: RTL
=========================

Name: fade_cycle_sequencer

Overview:
- Owns the day/night fade datapath: generates the 8-bit fade_level plus direction from a programmable tick prescaler and a four-phase state machine (night hold, rise, day hold, fall).
- Adds configurable step period, hold durations and step size, an enable/pause input, and a valid/ready config handshake that is accepted only at safe points.
- Feeds the PWM/colour stages that consume fade_level and direction.

Parameters:
- STEP, 1, fade_level increment/decrement per tick (1..255).
- DEF_PERIOD, 20'd1048575, step period in clocks loaded at reset.
- DEF_HOLD, 8'd0, hold length loaded at reset (day and night).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  1 = run; 0 = freeze prescaler and state
- cfg_valid  in  1  config request
- cfg_ready  out  1  config can be accepted this cycle
- cfg_period  in  20  clocks per tick (0 treated as 1)
- cfg_hold  in  8  hold length in ticks, applied to both hold phases
- fade_level  out  8  current brightness level
- direction  out  1  0 = heading to day (night hold/rise), 1 = heading to night (day hold/fall)
- phase  out  2  00 NIGHT_HOLD, 01 RISE, 10 DAY_HOLD, 11 FALL
- tick  out  1  one-cycle pulse on every prescaler tick (registered)

Behaviour:
- Reset values:
  - fade_level=0, direction=0, phase=NIGHT_HOLD, tick=0.
  - Internal: prescaler=0, hold_cnt=0, period_r=DEF_PERIOD, hold_r=DEF_HOLD.
  - cfg_ready=1.
- Reset wins over everything, mid-operation included; outputs take reset values on the cycle after rst is sampled high.
- Prescaler: 20-bit. While enable=1, it counts 0..eff_period-1, where eff_period = max(period_r,1).
  - On the cycle it equals eff_period-1, it wraps to 0 and an internal tick fires.
  - The tick output is registered, so it is high the cycle after the internal tick.
  - State and fade_level update on the same edge the tick output rises.
- enable=0: prescaler, hold_cnt, phase and fade_level all hold; no ticks.
- FSM actions occur only on an internal tick:
  - NIGHT_HOLD: if hold_cnt==hold_r, go to RISE and clear hold_cnt; else hold_cnt+1. The phase lasts hold_r+1 ticks.
  - RISE: if fade_level+STEP >= 255, fade_level=255, go to DAY_HOLD, direction=1. Else fade_level+=STEP. Use 9-bit add; no wrap allowed.
  - DAY_HOLD: same as NIGHT_HOLD, then go to FALL.
  - FALL: if fade_level <= STEP, fade_level=0, go to NIGHT_HOLD, direction=0. Else fade_level-=STEP. No underflow.
  - direction changes only on hold-phase entry; it equals phase[1].
- Config handshake:
  - cfg_ready = (phase is NIGHT_HOLD or DAY_HOLD) or enable==0. It is combinational from registered state plus enable.
  - A transfer happens when cfg_valid && cfg_ready.
  - On transfer, period_r/hold_r load on the next edge, the prescaler clears to 0 and hold_cnt clears to 0. Phase and fade_level are untouched.
  - cfg_valid while cfg_ready=0: the request is held pending with no effect. The requester must keep cfg_valid and data stable until ready.
- Simultaneous transfer and internal tick: the FSM step uses the old hold_r and is applied. The new config still loads. The prescaler and hold_cnt clear; the config clear overrides the tick update of hold_cnt, but a phase exit still happens.
- cfg_period=0 gives one tick per clock.
- fade_level never leaves 0..255. Both endpoints are always reached exactly.

Test Plan:
- Reset mid-ramp: cfg_period=1, run to fade_level=100 in RISE, pulse rst one cycle -> next cycle fade_level=0, phase=00, direction=0, tick=0, cfg_ready=1.
- Basic ramp (STEP=1): after reset, transfer cfg_period=4, cfg_hold=2, enable=1.
  - Expect tick every 4 clocks; NIGHT_HOLD lasts 3 ticks.
  - fade_level=1 on the 4th tick; 255 and phase=10, direction=1 on tick 258.
  - DAY_HOLD lasts 3 ticks; fade_level=0 and phase=00 on tick 516.
- Saturation (STEP=16, cfg_period=1, hold=0):
  - Rise sequence 0,16,…,240,255, reaching 255 on the 16th rise tick.
  - Fall sequence 239,…,15,0, reaching 0 on the 16th fall tick; never wraps.
- Handshake gating: assert cfg_valid with cfg_period=2 during RISE -> cfg_ready=0 and period unchanged until DAY_HOLD entry. Then one transfer occurs, and the next tick comes 2 clocks later.
- Pause: drop enable for 50 cycles at fade_level=77 in FALL -> fade_level, phase and prescaler frozen, no tick pulses, cfg_ready=1. On resume, the next tick comes after the remaining prescaler count.
- Collision: cfg transfer on the same cycle as the tick that ends NIGHT_HOLD -> phase moves to RISE, new period_r/hold_r loaded, prescaler=0, hold_cnt=0.

Source files
------------

// File: rtl/fade_cycle_sequencer.sv
// Day/night fade generator: prescaled ticks drive a four-phase FSM (night hold, rise, day hold, fall).
// Outputs are registered; a config write is accepted only in a hold phase or while paused.
module fade_cycle_sequencer #(
  parameter int unsigned STEP       = 1,
  parameter logic [19:0] DEF_PERIOD = 20'd1048575,
  parameter logic [7:0]  DEF_HOLD   = 8'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [19:0] cfg_period,
  input  logic [7:0]  cfg_hold,
  output logic [7:0]  fade_level,
  output logic        direction,
  output logic [1:0]  phase,
  output logic        tick
);

  typedef enum logic [1:0] {
    NIGHT_HOLD = 2'b00,
    RISE       = 2'b01,
    DAY_HOLD   = 2'b10,
    FALL       = 2'b11
  } phase_t;

  localparam logic [7:0] STEP8 = 8'(STEP);
  localparam logic [8:0] STEP9 = 9'(STEP);

  phase_t      state_q, state_d;
  logic [7:0]  level_q, level_d;
  logic [19:0] presc_q, presc_d;
  logic [7:0]  hold_cnt_q, hold_cnt_d;
  logic [19:0] period_q;
  logic [7:0]  hold_q;
  logic        tick_q;

  logic [19:0] eff_period;
  logic        int_tick;
  logic        xfer;
  logic [8:0]  sum;

  assign eff_period = (period_q == 20'd0) ? 20'd1 : period_q;
  assign int_tick   = enable && (presc_q == eff_period - 20'd1);
  assign cfg_ready  = (state_q == NIGHT_HOLD) || (state_q == DAY_HOLD) || !enable;
  assign xfer       = cfg_valid && cfg_ready;
  assign sum        = {1'b0, level_q} + STEP9;

  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    presc_d    = presc_q;
    hold_cnt_d = hold_cnt_q;

    if (enable) begin
      presc_d = int_tick ? 20'd0 : presc_q + 20'd1;
    end

    if (int_tick) begin
      case (state_q)
        NIGHT_HOLD, DAY_HOLD: begin
          if (hold_cnt_q == hold_q) begin
            hold_cnt_d = 8'd0;
            state_d    = (state_q == NIGHT_HOLD) ? RISE : FALL;
          end else begin
            hold_cnt_d = hold_cnt_q + 8'd1;
          end
        end
        RISE: begin
          // 9-bit sum so the top endpoint saturates instead of wrapping
          if (sum >= 9'd255) begin
            level_d = 8'hFF;
            state_d = DAY_HOLD;
          end else begin
            level_d = sum[7:0];
          end
        end
        FALL: begin
          if (level_q <= STEP8) begin
            level_d = 8'd0;
            state_d = NIGHT_HOLD;
          end else begin
            level_d = level_q - STEP8;
          end
        end
        default: state_d = state_q;
      endcase
    end

    // A config write restarts timing; it wins over the tick's counter updates but not the phase step.
    if (xfer) begin
      presc_d    = 20'd0;
      hold_cnt_d = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= NIGHT_HOLD;
      level_q    <= 8'd0;
      presc_q    <= 20'd0;
      hold_cnt_q <= 8'd0;
      period_q   <= DEF_PERIOD;
      hold_q     <= DEF_HOLD;
      tick_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      presc_q    <= presc_d;
      hold_cnt_q <= hold_cnt_d;
      tick_q     <= int_tick;
      if (xfer) begin
        period_q <= cfg_period;
        hold_q   <= cfg_hold;
      end
    end
  end

  assign fade_level = level_q;
  assign phase      = state_q;
  assign direction  = state_q[1];
  assign tick       = tick_q;

endmodule
